warp_register_block: RTL and testbench
======================================

// Module: warp_register_block
// PURPOSE
//  Per-warp, per-lane general-purpose register file of a SIMT core: 16 lanes x 16 warps x 64 regs x 32 b.
//  One shared write port and two shared read ports (addresses common to all lanes, enables per lane).
//  warp_selector picks the warp context for both reads and writes.
//  Feeds operand collection; written back from the execute/writeback stage.
// PARAMETERS
//  NUM_LANES  16  SIMD lanes; one bank per lane.
//  NUM_WARPS  16  warp contexts; WS_W = $clog2(NUM_WARPS) = 4.
//  NUM_REGS   64  registers per lane per warp; AW = $clog2(NUM_REGS) = 6.
//  DATA_W     32  register width.
// PORTS
//  clk            in   1          sole clock; all state updates on rising edge.
//  rst            in   1          synchronous, active-high reset.
//  warp_selector  in   WS_W       warp context for reads and writes.
//  write_en       in   NUM_LANES  bit l enables write of lane l.
//  waddr          in   AW         write register index (all lanes).
//  wdata_<l>      in   DATA_W     write data for lane l, l = 0..15.
//  read_en_0      in   NUM_LANES  bit l enables read port 0 of lane l.
//  raddr_0        in   AW         read port 0 register index.
//  read_en_1      in   NUM_LANES  bit l enables read port 1 of lane l.
//  raddr_1        in   AW         read port 1 register index.
//  rdata_0_<l>    out  DATA_W     port 0 data, lane l.
//  rdata_1_<l>    out  DATA_W     port 1 data, lane l.
// BEHAVIOUR
//  - Storage mem[lane][warp][reg]; not cleared by reset; contents undefined until written.
//  - Write: at posedge clk with rst=0, for each l with write_en[l]=1:
//    mem[l][warp_selector][waddr] <= wdata_<l>. Lanes with write_en[l]=0 keep their contents.
//  - Read: combinational, zero latency. rdata_p_<l> = read_en_p[l] ? mem[l][warp_selector][raddr_p] : 0.
//  - Disabled lane or port drives all-zero; both ports independent, may use the same address.
//  - Value written at edge N is readable right after edge N (same cycle after the edge, before edge N+1).
//  - Read of the address being written in the same cycle returns the old value.
//    This holds unless the bypass feature below is enabled.
//  - While rst=1: all rdata outputs forced to 0 and writes suppressed.
//    Storage is kept; reset asserted mid-operation loses no data.
//  - Warps are fully isolated: a write under warp w never alters any other warp.
//  - waddr/raddr/warp_selector cover the full range; no out-of-range case exists.
// CONFIGURATION
//  REGISTER_BLOCK_BYPASS_EN defined:
//    If write_en[l]=1, read_en_p[l]=1 and raddr_p==waddr in the same cycle, rdata_p_<l> = wdata_<l>.
//    This is a combinational write-to-read forward, applied per lane and per port.
//  REGISTER_BLOCK_BYPASS_EN undefined: no forwarding; the old stored value is returned.
// STRUCTURE
//  - Package register_block_pkg holds NUM_LANES, NUM_WARPS, NUM_REGS, DATA_W, WS_W and AW.
//  - It also holds typedefs: reg_addr_t logic[AW-1:0], warp_id_t logic[WS_W-1:0],
//    reg_data_t logic[DATA_W-1:0], lane_mask_t logic[NUM_LANES-1:0].
//  - Sub-module lane_reg_bank: one lane's NUM_WARPS*NUM_REGS x DATA_W array.
//    It has 1 write port, 2 async read ports, read-enable zeroing and the optional bypass.
//  - Top generates 16 lane_reg_bank instances and maps the flat per-lane wdata/rdata ports.
// TESTING
//  1. Reset: rst=1, read_en_0=read_en_1=16'hFFFF -> all 32 rdata outputs = 0.
//     Drive write_en=16'hFFFF with rst=1, then read -> no write occurred.
//  2. Per warp w=0..15, per reg r=0..63: write 16 random lanes with write_en=16'hFFFF.
//     Read port 0, then port 1, then both with raddr_0=raddr_1=r -> every lane matches its data.
//  3. Lane mask: warp 3, reg 5: write all lanes 32'hAAAA_0000+l, then write_en=16'h0001 with 32'h1234_5678.
//     -> lane 0 reads 32'h1234_5678; lanes 1..15 keep 32'hAAAA_0000+l.
//  4. Warp isolation: reg 7 = 32'hDEAD_BEEF in warp 2, reg 7 = 32'h0BAD_F00D in warp 9.
//     Select warp 2 -> 32'hDEAD_BEEF; select warp 9 -> 32'h0BAD_F00D.
//  5. Read enables: read_en_0=16'h00FF, read_en_1=16'hFF00 -> port 0 lanes 8..15 = 0, port 1 lanes 0..7 = 0.
//     All other lanes return stored data.
//  6. Same-cycle read/write to reg 10 (old 32'h1, new 32'h2).
//     Without the macro -> 32'h1 before the edge; with REGISTER_BLOCK_BYPASS_EN -> 32'h2; 32'h2 after the edge in both builds.

Source files
------------

// File: rtl/register_block_pkg.sv
// register_block_pkg: shared sizes and types for the SIMT warp register file.
package register_block_pkg;
    localparam int NUM_LANES = 16;
    localparam int NUM_WARPS = 16;
    localparam int NUM_REGS  = 64;
    localparam int DATA_W    = 32;
    localparam int WS_W      = $clog2(NUM_WARPS);
    localparam int AW        = $clog2(NUM_REGS);
    typedef logic [AW-1:0]        reg_addr_t;
    typedef logic [WS_W-1:0]      warp_id_t;
    typedef logic [DATA_W-1:0]    reg_data_t;
    typedef logic [NUM_LANES-1:0] lane_mask_t;
endpackage

// File: rtl/lane_reg_bank.sv
// lane_reg_bank: one lane's warp x register storage, 1 write / 2 async read ports.
// Optional write-to-read forwarding under REGISTER_BLOCK_BYPASS_EN.
module lane_reg_bank
    import register_block_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  warp_id_t  warp_selector,
    input  logic      write_en,
    input  reg_addr_t waddr,
    input  reg_data_t wdata,
    input  logic      read_en_0,
    input  reg_addr_t raddr_0,
    input  logic      read_en_1,
    input  reg_addr_t raddr_1,
    output reg_data_t rdata_0,
    output reg_data_t rdata_1
);
    // Storage deliberately has no reset so contents survive rst.
    reg_data_t mem [NUM_WARPS*NUM_REGS];
    logic fwd_0, fwd_1;
    always_ff @(posedge clk)
        if (!rst && write_en) mem[{warp_selector, waddr}] <= wdata;
`ifdef REGISTER_BLOCK_BYPASS_EN
    assign fwd_0 = write_en && (raddr_0 == waddr);
    assign fwd_1 = write_en && (raddr_1 == waddr);
`else
    assign fwd_0 = 1'b0;
    assign fwd_1 = 1'b0;
`endif
    always_comb begin
        rdata_0 = (rst || !read_en_0) ? '0 : fwd_0 ? wdata : mem[{warp_selector, raddr_0}];
        rdata_1 = (rst || !read_en_1) ? '0 : fwd_1 ? wdata : mem[{warp_selector, raddr_1}];
    end
endmodule

// File: rtl/warp_register_block.sv
// warp_register_block: 16-lane x 16-warp x 64-reg SIMT register file.
// Define REGISTER_BLOCK_BYPASS_EN to forward same-cycle writes to reads.
module warp_register_block
    import register_block_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  warp_selector,
    input  logic [15:0] write_en,
    input  logic [5:0]  waddr,
    input  logic [31:0] wdata_0,
    input  logic [31:0] wdata_1,
    input  logic [31:0] wdata_2,
    input  logic [31:0] wdata_3,
    input  logic [31:0] wdata_4,
    input  logic [31:0] wdata_5,
    input  logic [31:0] wdata_6,
    input  logic [31:0] wdata_7,
    input  logic [31:0] wdata_8,
    input  logic [31:0] wdata_9,
    input  logic [31:0] wdata_10,
    input  logic [31:0] wdata_11,
    input  logic [31:0] wdata_12,
    input  logic [31:0] wdata_13,
    input  logic [31:0] wdata_14,
    input  logic [31:0] wdata_15,
    input  logic [15:0] read_en_0,
    input  logic [5:0]  raddr_0,
    input  logic [15:0] read_en_1,
    input  logic [5:0]  raddr_1,
    output logic [31:0] rdata_0_0,
    output logic [31:0] rdata_0_1,
    output logic [31:0] rdata_0_2,
    output logic [31:0] rdata_0_3,
    output logic [31:0] rdata_0_4,
    output logic [31:0] rdata_0_5,
    output logic [31:0] rdata_0_6,
    output logic [31:0] rdata_0_7,
    output logic [31:0] rdata_0_8,
    output logic [31:0] rdata_0_9,
    output logic [31:0] rdata_0_10,
    output logic [31:0] rdata_0_11,
    output logic [31:0] rdata_0_12,
    output logic [31:0] rdata_0_13,
    output logic [31:0] rdata_0_14,
    output logic [31:0] rdata_0_15,
    output logic [31:0] rdata_1_0,
    output logic [31:0] rdata_1_1,
    output logic [31:0] rdata_1_2,
    output logic [31:0] rdata_1_3,
    output logic [31:0] rdata_1_4,
    output logic [31:0] rdata_1_5,
    output logic [31:0] rdata_1_6,
    output logic [31:0] rdata_1_7,
    output logic [31:0] rdata_1_8,
    output logic [31:0] rdata_1_9,
    output logic [31:0] rdata_1_10,
    output logic [31:0] rdata_1_11,
    output logic [31:0] rdata_1_12,
    output logic [31:0] rdata_1_13,
    output logic [31:0] rdata_1_14,
    output logic [31:0] rdata_1_15
);
    reg_data_t wd [NUM_LANES];
    reg_data_t r0 [NUM_LANES];
    reg_data_t r1 [NUM_LANES];
    assign wd[0]  = wdata_0;
    assign wd[1]  = wdata_1;
    assign wd[2]  = wdata_2;
    assign wd[3]  = wdata_3;
    assign wd[4]  = wdata_4;
    assign wd[5]  = wdata_5;
    assign wd[6]  = wdata_6;
    assign wd[7]  = wdata_7;
    assign wd[8]  = wdata_8;
    assign wd[9]  = wdata_9;
    assign wd[10] = wdata_10;
    assign wd[11] = wdata_11;
    assign wd[12] = wdata_12;
    assign wd[13] = wdata_13;
    assign wd[14] = wdata_14;
    assign wd[15] = wdata_15;
    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            lane_reg_bank u_bank (
                .clk           (clk),
                .rst           (rst),
                .warp_selector (warp_selector),
                .write_en      (write_en[i]),
                .waddr         (waddr),
                .wdata         (wd[i]),
                .read_en_0     (read_en_0[i]),
                .raddr_0       (raddr_0),
                .read_en_1     (read_en_1[i]),
                .raddr_1       (raddr_1),
                .rdata_0       (r0[i]),
                .rdata_1       (r1[i])
            );
        end
    endgenerate
    assign rdata_0_0  = r0[0];
    assign rdata_0_1  = r0[1];
    assign rdata_0_2  = r0[2];
    assign rdata_0_3  = r0[3];
    assign rdata_0_4  = r0[4];
    assign rdata_0_5  = r0[5];
    assign rdata_0_6  = r0[6];
    assign rdata_0_7  = r0[7];
    assign rdata_0_8  = r0[8];
    assign rdata_0_9  = r0[9];
    assign rdata_0_10 = r0[10];
    assign rdata_0_11 = r0[11];
    assign rdata_0_12 = r0[12];
    assign rdata_0_13 = r0[13];
    assign rdata_0_14 = r0[14];
    assign rdata_0_15 = r0[15];
    assign rdata_1_0  = r1[0];
    assign rdata_1_1  = r1[1];
    assign rdata_1_2  = r1[2];
    assign rdata_1_3  = r1[3];
    assign rdata_1_4  = r1[4];
    assign rdata_1_5  = r1[5];
    assign rdata_1_6  = r1[6];
    assign rdata_1_7  = r1[7];
    assign rdata_1_8  = r1[8];
    assign rdata_1_9  = r1[9];
    assign rdata_1_10 = r1[10];
    assign rdata_1_11 = r1[11];
    assign rdata_1_12 = r1[12];
    assign rdata_1_13 = r1[13];
    assign rdata_1_14 = r1[14];
    assign rdata_1_15 = r1[15];
endmodule

// File: tb/tb_warp_register_block.sv
// tb_warp_register_block: randomized checks of warp_register_block against an array model.
module tb_warp_register_block;
    logic clk = 1'b0;
    logic rst;
    logic [3:0]  ws;
    logic [15:0] we, re0, re1;
    logic [5:0]  wa, ra0, ra1;
    logic [31:0] wd  [16];
    logic [31:0] rd0 [16];
    logic [31:0] rd1 [16];
    logic [31:0] model [16][16][64];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    warp_register_block dut (
        .clk(clk), .rst(rst), .warp_selector(ws), .write_en(we), .waddr(wa),
        .wdata_0(wd[0]), .wdata_1(wd[1]), .wdata_2(wd[2]), .wdata_3(wd[3]),
        .wdata_4(wd[4]), .wdata_5(wd[5]), .wdata_6(wd[6]), .wdata_7(wd[7]),
        .wdata_8(wd[8]), .wdata_9(wd[9]), .wdata_10(wd[10]), .wdata_11(wd[11]),
        .wdata_12(wd[12]), .wdata_13(wd[13]), .wdata_14(wd[14]), .wdata_15(wd[15]),
        .read_en_0(re0), .raddr_0(ra0), .read_en_1(re1), .raddr_1(ra1),
        .rdata_0_0(rd0[0]), .rdata_0_1(rd0[1]), .rdata_0_2(rd0[2]), .rdata_0_3(rd0[3]),
        .rdata_0_4(rd0[4]), .rdata_0_5(rd0[5]), .rdata_0_6(rd0[6]), .rdata_0_7(rd0[7]),
        .rdata_0_8(rd0[8]), .rdata_0_9(rd0[9]), .rdata_0_10(rd0[10]), .rdata_0_11(rd0[11]),
        .rdata_0_12(rd0[12]), .rdata_0_13(rd0[13]), .rdata_0_14(rd0[14]), .rdata_0_15(rd0[15]),
        .rdata_1_0(rd1[0]), .rdata_1_1(rd1[1]), .rdata_1_2(rd1[2]), .rdata_1_3(rd1[3]),
        .rdata_1_4(rd1[4]), .rdata_1_5(rd1[5]), .rdata_1_6(rd1[6]), .rdata_1_7(rd1[7]),
        .rdata_1_8(rd1[8]), .rdata_1_9(rd1[9]), .rdata_1_10(rd1[10]), .rdata_1_11(rd1[11]),
        .rdata_1_12(rd1[12]), .rdata_1_13(rd1[13]), .rdata_1_14(rd1[14]), .rdata_1_15(rd1[15])
    );

    // Expected read value: disabled lane or reset gives zero, otherwise the model contents.
    function automatic logic [31:0] expect_rd(int l, logic [3:0] w, logic [5:0] a, logic [15:0] en);
        return (rst || !en[l]) ? 32'h0 : model[l][w][a];
    endfunction

    task automatic do_write(input logic [3:0] w, input logic [5:0] a, input logic [15:0] m);
        @(negedge clk);
        ws = w; wa = a; we = m;
        @(posedge clk);
        #1;
        we = '0;
        if (!rst)
            for (int l = 0; l < 16; l++) if (m[l]) model[l][w][a] = wd[l];
    endtask

    task automatic set_read(input logic [3:0] w, input logic [5:0] a0, input logic [15:0] e0,
                            input logic [5:0] a1, input logic [15:0] e1);
        @(negedge clk);
        ws = w; ra0 = a0; re0 = e0; ra1 = a1; re1 = e1;
        #1;
    endtask

    task automatic test_reset();
        set_read(0, 0, 16'hFFFF, 0, 16'hFFFF);
        for (int l = 0; l < 16; l++) begin
            vectors++;
            if (rd0[l] !== 32'h0 || rd1[l] !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_out lane %0d: got %h/%h want 0", l, rd0[l], rd1[l]);
            end
        end
        rst = 1'b0;
        for (int l = 0; l < 16; l++) wd[l] = $urandom;
        do_write(0, 0, 16'hFFFF);
        rst = 1'b1;
        for (int l = 0; l < 16; l++) wd[l] = ~model[l][0][0];
        do_write(0, 0, 16'hFFFF);
        set_read(0, 0, 16'hFFFF, 0, 16'hFFFF);
        for (int l = 0; l < 16; l++) begin
            vectors++;
            if (rd0[l] !== 32'h0 || rd1[l] !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_force_zero lane %0d: got %h/%h want 0", l, rd0[l], rd1[l]);
            end
        end
        rst = 1'b0;
        set_read(0, 0, 16'hFFFF, 0, 16'hFFFF);
        for (int l = 0; l < 16; l++) begin
            vectors++;
            if (rd0[l] !== model[l][0][0] || rd1[l] !== model[l][0][0]) begin
                miscompares++;
                $display("FAIL reset_write_suppressed lane %0d: got %h/%h want %h", l, rd0[l], rd1[l], model[l][0][0]);
            end
        end
    endtask

    task automatic test_all_regs();
        for (int w = 0; w < 16; w++)
            for (int r = 0; r < 64; r++) begin
                for (int l = 0; l < 16; l++) wd[l] = $urandom;
                do_write(w[3:0], r[5:0], 16'hFFFF);
                for (int p = 0; p < 3; p++) begin
                    logic [15:0] e0, e1;
                    e0 = (p != 1) ? 16'hFFFF : 16'h0;
                    e1 = (p != 0) ? 16'hFFFF : 16'h0;
                    set_read(w[3:0], r[5:0], e0, r[5:0], e1);
                    for (int l = 0; l < 16; l++) begin
                        vectors++;
                        if (rd0[l] !== expect_rd(l, w[3:0], r[5:0], e0) ||
                            rd1[l] !== expect_rd(l, w[3:0], r[5:0], e1)) begin
                            miscompares++;
                            $display("FAIL all_regs w%0d r%0d lane %0d mode %0d: got %h/%h want %h/%h", w, r, l, p,
                                     rd0[l], rd1[l], expect_rd(l, w[3:0], r[5:0], e0), expect_rd(l, w[3:0], r[5:0], e1));
                        end
                    end
                end
            end
    endtask

    task automatic test_lane_mask();
        for (int l = 0; l < 16; l++) wd[l] = 32'hAAAA_0000 + l;
        do_write(3, 5, 16'hFFFF);
        for (int l = 0; l < 16; l++) wd[l] = 32'h1234_5678;
        do_write(3, 5, 16'h0001);
        set_read(3, 5, 16'hFFFF, 5, 16'hFFFF);
        for (int l = 0; l < 16; l++) begin
            logic [31:0] want;
            want = (l == 0) ? 32'h1234_5678 : 32'hAAAA_0000 + l;
            vectors++;
            if (rd0[l] !== want || rd1[l] !== want) begin
                miscompares++;
                $display("FAIL lane_mask lane %0d: got %h/%h want %h", l, rd0[l], rd1[l], want);
            end
        end
    endtask

    task automatic test_warp_isolation();
        for (int l = 0; l < 16; l++) wd[l] = 32'hDEAD_BEEF;
        do_write(2, 7, 16'hFFFF);
        for (int l = 0; l < 16; l++) wd[l] = 32'h0BAD_F00D;
        do_write(9, 7, 16'hFFFF);
        for (int k = 0; k < 2; k++) begin
            logic [3:0] w;
            logic [31:0] want;
            w = (k == 0) ? 4'd2 : 4'd9;
            want = (k == 0) ? 32'hDEAD_BEEF : 32'h0BAD_F00D;
            set_read(w, 7, 16'hFFFF, 7, 16'hFFFF);
            for (int l = 0; l < 16; l++) begin
                vectors++;
                if (rd0[l] !== want || rd1[l] !== want) begin
                    miscompares++;
                    $display("FAIL warp_isolation w%0d lane %0d: got %h/%h want %h", w, l, rd0[l], rd1[l], want);
                end
            end
        end
    endtask

    task automatic test_read_enables();
        for (int t = 0; t < 10; t++) begin
            logic [3:0] w;
            logic [5:0] a0, a1;
            logic [15:0] e0, e1;
            w = 4'($urandom); a0 = 6'($urandom); a1 = 6'($urandom);
            e0 = (t == 0) ? 16'h00FF : 16'($urandom);
            e1 = (t == 0) ? 16'hFF00 : 16'($urandom);
            set_read(w, a0, e0, a1, e1);
            for (int l = 0; l < 16; l++) begin
                vectors++;
                if (rd0[l] !== expect_rd(l, w, a0, e0) || rd1[l] !== expect_rd(l, w, a1, e1)) begin
                    miscompares++;
                    $display("FAIL read_enable t%0d lane %0d: got %h/%h want %h/%h", t, l, rd0[l], rd1[l],
                             expect_rd(l, w, a0, e0), expect_rd(l, w, a1, e1));
                end
            end
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] pre;
`ifdef REGISTER_BLOCK_BYPASS_EN
        pre = 32'h2;
`else
        pre = 32'h1;
`endif
        for (int l = 0; l < 16; l++) wd[l] = 32'h1;
        do_write(4, 10, 16'hFFFF);
        @(negedge clk);
        for (int l = 0; l < 16; l++) wd[l] = 32'h2;
        ws = 4; wa = 10; we = 16'hFFFF; ra0 = 10; re0 = 16'hFFFF; ra1 = 10; re1 = 16'hFFFF;
        #1;
        for (int l = 0; l < 16; l++) begin
            vectors++;
            if (rd0[l] !== pre || rd1[l] !== pre) begin
                miscompares++;
                $display("FAIL same_cycle_before lane %0d: got %h/%h want %h", l, rd0[l], rd1[l], pre);
            end
        end
        @(posedge clk);
        #1;
        for (int l = 0; l < 16; l++) begin
            vectors++;
            if (rd0[l] !== 32'h2 || rd1[l] !== 32'h2) begin
                miscompares++;
                $display("FAIL same_cycle_after lane %0d: got %h/%h want 2", l, rd0[l], rd1[l]);
            end
        end
        we = '0;
        for (int l = 0; l < 16; l++) model[l][4][10] = 32'h2;
    endtask

    initial begin
        rst = 1'b1; ws = '0; we = '0; wa = '0; re0 = '0; re1 = '0; ra0 = '0; ra1 = '0;
        for (int l = 0; l < 16; l++) wd[l] = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_all_regs();
        test_lane_mask();
        test_warp_isolation();
        test_read_enables();
        test_same_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
